// File: rtl/traffic_fsm.sv
// Two-road traffic light controller with flashing-yellow fail-safe.
// Optional pedestrian walk logic is enabled by defining TRAFFIC_PED_WALK_EN.
module traffic_fsm #(
  parameter int FLASH_HALF_PERIOD = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       time_out,
  input  logic       fault,
  input  logic       ped_req,
  output logic [1:0] c_state,
  output logic [2:0] main_light,
  output logic [2:0] side_light,
  output logic       tmr_rst,
  output logic       flash_active,
  output logic       ped_walk,
  output logic       ped_ack
);

  // Low two bits double as the phase code reported to the timer.
  typedef enum logic [2:0] {
    MG    = 3'b000,
    MY    = 3'b010,
    SG    = 3'b011,
    SY    = 3'b001,
    FLASH = 3'b100
  } state_t;

  localparam logic [7:0] HP_LAST = 8'(FLASH_HALF_PERIOD - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       blink_q, blink_d;
  logic [1:0] c_state_q, c_state_d;
  logic [2:0] main_q, main_d;
  logic [2:0] side_q, side_d;
  logic       tmr_q, tmr_d;

  // Phase sequencing, fault override and blink timing.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    blink_d = blink_q;
    if (fault) begin
      state_d = FLASH;
      if (state_q != FLASH) begin
        cnt_d   = 8'd0;
        blink_d = 1'b1;
      end else if (cnt_q == HP_LAST) begin
        cnt_d   = 8'd0;
        blink_d = ~blink_q;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end else if (state_q == FLASH) begin
      state_d = MG;
      cnt_d   = 8'd0;
      blink_d = 1'b0;
    end else if (time_out) begin
      unique case (state_q)
        MG:      state_d = MY;
        MY:      state_d = SG;
        SG:      state_d = SY;
        SY:      state_d = MG;
        default: state_d = MG;
      endcase
    end
  end

  // Lamp and timer outputs decoded from the upcoming state.
  always_comb begin
    c_state_d = state_d[1:0];
    tmr_d     = (state_d == FLASH);
    main_d    = 3'b100;
    side_d    = 3'b100;
    unique case (state_d)
      MG: begin
        main_d = 3'b001;
        side_d = 3'b100;
      end
      MY: begin
        main_d = 3'b010;
        side_d = 3'b100;
      end
      SG: begin
        main_d = 3'b100;
        side_d = 3'b001;
      end
      SY: begin
        main_d = 3'b100;
        side_d = 3'b010;
      end
      default: begin
        main_d = {1'b0, blink_d, 1'b0};
        side_d = {1'b0, blink_d, 1'b0};
      end
    endcase
  end

  // Core state and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= MG;
      cnt_q     <= 8'd0;
      blink_q   <= 1'b0;
      c_state_q <= 2'b00;
      main_q    <= 3'b001;
      side_q    <= 3'b100;
      tmr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      blink_q   <= blink_d;
      c_state_q <= c_state_d;
      main_q    <= main_d;
      side_q    <= side_d;
      tmr_q     <= tmr_d;
    end
  end

  assign c_state      = c_state_q;
  assign main_light   = main_q;
  assign side_light   = side_q;
  assign tmr_rst      = tmr_q;
  assign flash_active = tmr_q;

`ifdef TRAFFIC_PED_WALK_EN
  logic pend_q, pend_d;
  logic walk_q, walk_d;
  logic ack_q, ack_d;
  logic enter_sg;

  // Request latch; a pending request is served on the next MY->SG entry.
  always_comb begin
    enter_sg = (state_q == MY) && (state_d == SG);
    pend_d   = pend_q | ped_req;
    ack_d    = 1'b0;
    if (state_d == FLASH) begin
      pend_d = 1'b0;
    end else if (enter_sg && pend_q) begin
      pend_d = ped_req;
      ack_d  = 1'b1;
    end
    walk_d = (state_d == SG) && (walk_q || (enter_sg && pend_q));
  end

  // Pedestrian registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= 1'b0;
      walk_q <= 1'b0;
      ack_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      walk_q <= walk_d;
      ack_q  <= ack_d;
    end
  end

  assign ped_walk = walk_q;
  assign ped_ack  = ack_q;
`else
  logic ped_unused;
  assign ped_unused = ped_req;
  assign ped_walk   = 1'b0;
  assign ped_ack    = 1'b0;
`endif

endmodule

// File: tb/tb_traffic_fsm.sv
// Directed self-checking bench for traffic_fsm.
// Pedestrian scenarios follow the TRAFFIC_PED_WALK_EN build setting.
module tb_traffic_fsm;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       time_out = 1'b0;
  logic       fault = 1'b0;
  logic       ped_req = 1'b0;
  logic [1:0] c_state;
  logic [2:0] main_light;
  logic [2:0] side_light;
  logic       tmr_rst;
  logic       flash_active;
  logic       ped_walk;
  logic       ped_ack;

  int errors = 0;
  int checks = 0;

  traffic_fsm #(.FLASH_HALF_PERIOD(4)) dut (
    .clk(clk), .rst(rst), .time_out(time_out),
    .fault(fault), .ped_req(ped_req),
    .c_state(c_state), .main_light(main_light),
    .side_light(side_light), .tmr_rst(tmr_rst),
    .flash_active(flash_active),
    .ped_walk(ped_walk), .ped_ack(ped_ack)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse();
    time_out = 1'b1;
    tick();
    time_out = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; fault = 1'b1; time_out = 1'b1; ped_req = 1'b1;
    tick();
    rst = 1'b0; fault = 1'b0; time_out = 1'b0; ped_req = 1'b0;
    checks++;
    if (c_state !== 2'b00) begin errors++;
      $display("FAIL rst_cstate got=%b exp=00", c_state); end
    checks++;
    if (main_light !== 3'b001 || side_light !== 3'b100) begin errors++;
      $display("FAIL rst_lights got=%b/%b exp=001/100", main_light, side_light); end
    checks++;
    if (tmr_rst !== 1'b0 || flash_active !== 1'b0) begin errors++;
      $display("FAIL rst_tmr got=%b/%b exp=0/0", tmr_rst, flash_active); end
    checks++;
    if (ped_walk !== 1'b0 || ped_ack !== 1'b0) begin errors++;
      $display("FAIL rst_ped got=%b/%b exp=0/0", ped_walk, ped_ack); end
  endtask

  task automatic test_cycle();
    logic [1:0] codes [4];
    logic [2:0] mains [4];
    logic [2:0] sides [4];
    int idx;
    codes = '{2'b00, 2'b10, 2'b11, 2'b01};
    mains = '{3'b001, 3'b010, 3'b100, 3'b100};
    sides = '{3'b100, 3'b100, 3'b001, 3'b010};
    idx = 0;
    do_reset();
    for (int cyc = 1; cyc <= 30; cyc++) begin
      time_out = (cyc == 10 || cyc == 13 || cyc == 23 || cyc == 26);
      if (time_out) idx = (idx + 1) % 4;
      tick();
      checks++;
      if (c_state !== codes[idx]) begin errors++;
        $display("FAIL cycle_cstate c%0d got=%b exp=%b", cyc, c_state, codes[idx]); end
      checks++;
      if (main_light !== mains[idx] || side_light !== sides[idx]) begin errors++;
        $display("FAIL cycle_lights c%0d got=%b/%b exp=%b/%b",
                 cyc, main_light, side_light, mains[idx], sides[idx]); end
      checks++;
      if (tmr_rst !== 1'b0 || flash_active !== 1'b0) begin errors++;
        $display("FAIL cycle_tmr c%0d got=%b/%b exp=0/0", cyc, tmr_rst, flash_active); end
    end
    time_out = 1'b0;
  endtask

  task automatic test_flash();
    logic b;
    do_reset();
    pulse();
    pulse();
    checks++;
    if (c_state !== 2'b11) begin errors++;
      $display("FAIL flash_pre_sg got=%b exp=11", c_state); end
    fault = 1'b1; time_out = 1'b1;
    tick();
    time_out = 1'b0;
    checks++;
    if (tmr_rst !== 1'b1 || flash_active !== 1'b1) begin errors++;
      $display("FAIL flash_entry got=%b/%b exp=1/1", tmr_rst, flash_active); end
    for (int i = 0; i < 16; i++) begin
      b = ((i / 4) % 2) == 0;
      checks++;
      if (main_light !== {1'b0, b, 1'b0} || side_light !== {1'b0, b, 1'b0}) begin
        errors++;
        $display("FAIL flash_blink i%0d got=%b/%b exp=0%b0", i, main_light, side_light, b);
      end
      checks++;
      if (c_state !== 2'b00 || tmr_rst !== 1'b1) begin errors++;
        $display("FAIL flash_hold i%0d got=%b/%b exp=00/1", i, c_state, tmr_rst); end
      time_out = (i % 3 == 0);
      tick();
    end
    time_out = 1'b0;
  endtask

  task automatic test_release();
    fault = 1'b0;
    tick();
    checks++;
    if (c_state !== 2'b00 || main_light !== 3'b001 || side_light !== 3'b100) begin
      errors++;
      $display("FAIL release_mg got=%b %b/%b exp=00 001/100", c_state, main_light, side_light);
    end
    checks++;
    if (tmr_rst !== 1'b0 || flash_active !== 1'b0) begin errors++;
      $display("FAIL release_tmr got=%b/%b exp=0/0", tmr_rst, flash_active); end
    pulse();
    checks++;
    if (c_state !== 2'b10 || main_light !== 3'b010) begin errors++;
      $display("FAIL release_my got=%b/%b exp=10/010", c_state, main_light); end
  endtask

  task automatic test_reset_mid_flash();
    fault = 1'b1;
    tick();
    checks++;
    if (flash_active !== 1'b1) begin errors++;
      $display("FAIL midflash_enter got=%b exp=1", flash_active); end
    rst = 1'b1;
    tick();
    rst = 1'b0; fault = 1'b0;
    checks++;
    if (flash_active !== 1'b0 || tmr_rst !== 1'b0 || main_light !== 3'b001) begin
      errors++;
      $display("FAIL midflash_rst got=%b/%b/%b exp=0/0/001", flash_active, tmr_rst, main_light);
    end
  endtask

`ifdef TRAFFIC_PED_WALK_EN
  task automatic test_ped_walk();
    do_reset();
    ped_req = 1'b1;
    tick();
    ped_req = 1'b0;
    pulse();
    checks++;
    if (ped_walk !== 1'b0 || ped_ack !== 1'b0) begin errors++;
      $display("FAIL ped_my got=%b/%b exp=0/0", ped_walk, ped_ack); end
    pulse();
    checks++;
    if (ped_walk !== 1'b1 || ped_ack !== 1'b1) begin errors++;
      $display("FAIL ped_sg_entry got=%b/%b exp=1/1", ped_walk, ped_ack); end
    tick();
    checks++;
    if (ped_walk !== 1'b1 || ped_ack !== 1'b0) begin errors++;
      $display("FAIL ped_sg_hold got=%b/%b exp=1/0", ped_walk, ped_ack); end
    ped_req = 1'b1;
    tick();
    ped_req = 1'b0;
    pulse();
    checks++;
    if (c_state !== 2'b01 || ped_walk !== 1'b0) begin errors++;
      $display("FAIL ped_sy got=%b/%b exp=01/0", c_state, ped_walk); end
    pulse();
    pulse();
    checks++;
    if (ped_walk !== 1'b0 || ped_ack !== 1'b0) begin errors++;
      $display("FAIL ped_my2 got=%b/%b exp=0/0", ped_walk, ped_ack); end
    pulse();
    checks++;
    if (ped_walk !== 1'b1 || ped_ack !== 1'b1) begin errors++;
      $display("FAIL ped_sg2 got=%b/%b exp=1/1", ped_walk, ped_ack); end
  endtask

  task automatic test_ped_reset();
    ped_req = 1'b1;
    tick();
    ped_req = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (c_state !== 2'b00 || ped_walk !== 1'b0) begin errors++;
      $display("FAIL pedrst got=%b/%b exp=00/0", c_state, ped_walk); end
    pulse();
    pulse();
    checks++;
    if (c_state !== 2'b11 || ped_walk !== 1'b0 || ped_ack !== 1'b0) begin errors++;
      $display("FAIL pedrst_pend got=%b %b/%b exp=11 0/0", c_state, ped_walk, ped_ack); end
  endtask
`else
  task automatic test_no_ped();
    do_reset();
    ped_req = 1'b1;
    for (int i = 0; i < 12; i++) begin
      time_out = (i % 2 == 1);
      tick();
      checks++;
      if (ped_walk !== 1'b0 || ped_ack !== 1'b0) begin errors++;
        $display("FAIL noped i%0d got=%b/%b exp=0/0", i, ped_walk, ped_ack); end
    end
    ped_req = 1'b0;
    time_out = 1'b0;
    pulse();
    pulse();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (c_state !== 2'b00 || ped_walk !== 1'b0) begin errors++;
      $display("FAIL noped_rst got=%b/%b exp=00/0", c_state, ped_walk); end
  endtask
`endif

  initial begin
    test_reset();
    test_cycle();
    test_flash();
    test_release();
    test_reset_mid_flash();
`ifdef TRAFFIC_PED_WALK_EN
    test_ped_walk();
    test_ped_reset();
`else
    test_no_ped();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/traffic_fsm.md
TRAFFIC_FSM -- requirements
Module: traffic_fsm

Interface
REQ-001 SHALL have parameter FLASH_HALF_PERIOD, default 4: clock cycles per on/off phase of flashing yellow (legal range 1..255).
REQ-002 SHALL have port clk  input  1  single system clock; all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port time_out  input  1  one-cycle pulse from the countdown timer, meaning the current phase has expired.
REQ-005 SHALL have port fault  input  1  level; 1 requests flashing-yellow fail-safe mode.
REQ-006 SHALL have port ped_req  input  1  pedestrian button; any cycle high registers a request.
REQ-007 SHALL have port c_state  output  2  current phase code fed back to the timer: 00 main green/side red, 10 main yellow/side red, 11 main red/side green, 01 main red/side yellow.
REQ-008 SHALL have port main_light  output  3  one-hot {red,yellow,green} for the main road.
REQ-009 SHALL have port side_light  output  3  one-hot {red,yellow,green} for the side road.
REQ-010 SHALL have port tmr_rst  output  1  timer reload request, ORed with rst externally into the timer reset.
REQ-011 SHALL have port flash_active  output  1  high while in flash mode.
REQ-012 SHALL have ports ped_walk  output  1  walk lamp, and ped_ack  output  1  one-cycle acknowledge.

Function
REQ-013 SHALL implement states MG (00), MY (10), SG (11), SY (01), FLASH; all outputs registered.
REQ-014 SHALL, outside FLASH with fault=0, advance MG->MY->SG->SY->MG only at the edge where time_out=1; c_state reflects the new state the following cycle.
REQ-015 SHALL hold state while time_out=0; ignore time_out entirely in FLASH.
REQ-016 SHALL drive lights: MG main=001 side=100; MY main=010 side=100; SG main=100 side=001; SY main=100 side=010.
REQ-017 SHALL enter FLASH at the edge where fault=1, from any state, overriding a simultaneous time_out.
REQ-018 SHALL in FLASH drive c_state=00, flash_active=1, tmr_rst=1, main_light=side_light={0,blink,0}; blink starts 1 and toggles every FLASH_HALF_PERIOD cycles via an 8-bit counter.
REQ-019 SHALL leave FLASH to MG at the first edge with fault=0; tmr_rst=0 and blink counter cleared in that MG cycle, so the timer starts a full green phase aligned with MG.
REQ-020 SHALL keep tmr_rst=0 and flash_active=0 in all non-FLASH states.

Reset
REQ-021 SHALL on rst=1 at an edge enter MG: c_state=00, main_light=001, side_light=100, tmr_rst=0, flash_active=0, ped_walk=0, ped_ack=0, request latch cleared, blink counter=0; rst overrides fault, time_out and ped_req.
REQ-022 SHALL apply reset identically mid-phase, mid-walk and mid-flash.

Configuration
REQ-023 SHALL gate pedestrian logic with macro TRAFFIC_PED_WALK_EN.
REQ-024 SHALL, with TRAFFIC_PED_WALK_EN defined: latch ped_req into a pending flag; on a transition MY->SG with pending=1, assert ped_ack for one cycle and ped_walk for all of SG, clearing pending; ped_req during SG sets pending for the next cycle; pending clears in FLASH.
REQ-025 SHALL, without the macro, keep ports present, tie ped_walk=ped_ack=0 and ignore ped_req.

Verification
REQ-026 SHALL cover: reset, then time_out pulses at cycles 10,13,23,26 -> c_state 00->10->11->01->00 one cycle after each pulse, lights per REQ-016.
REQ-027 SHALL cover: fault=1 during SG together with time_out -> FLASH next cycle, tmr_rst=1, yellows 1 for 4 cycles, 0 for 4, repeating.
REQ-028 SHALL cover: fault released -> MG with main=001, tmr_rst=0 next cycle; then time_out -> MY.
REQ-029 SHALL cover (macro defined): ped_req pulse in MG -> ped_ack pulse on entry to SG, ped_walk=1 until SY, 0 thereafter; second ped_req during SG -> walk in next SG.
REQ-030 SHALL cover: rst=1 during SG with ped_walk=1 -> next cycle c_state=00, ped_walk=0, pending cleared; (macro undefined) ped_req never drives ped_walk/ped_ack.
